fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks the fetch address forward on icache hits and buffers
// {pc, inst} pairs in a circular queue for the decoder, with redirect and flush support.
module fetch_queue #(
   parameter int unsigned QUEUE_WIDTH = 3,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                 clockIn,
   input  logic                 resetIn,
   input  logic                 readyIn,
   output logic [31:0]          fetchOut,
   input  logic                 hit,
   input  logic [31:0]          icacheIn,
   output logic                 deqValid,
   output logic [31:0]          deqInst,
   output logic [31:0]          deqPC,
   input  logic                 deqReady,
   input  logic                 redirectFlag,
   input  logic [31:0]          redirectPC,
   input  logic                 clearIn,
   input  logic [31:0]          setPCVal,
   output logic [QUEUE_WIDTH:0] countOut,
   output logic                 fullOut,
   output logic                 emptyOut
);

   localparam int unsigned Depth = 1 << QUEUE_WIDTH;

   logic [QUEUE_WIDTH-1:0] head_q, head_d;
   logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
   logic [QUEUE_WIDTH:0]   count_q, count_d;
   logic [31:0]            fetch_q, fetch_d;
   logic [31:0]            pc_mem_q   [Depth];
   logic [31:0]            inst_mem_q [Depth];

   logic empty, full;
   logic flush, redirect, enq, deq;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == (QUEUE_WIDTH+1)'(Depth));

      // A redirect with nothing at the head has no jumping instruction behind it, so it is ignored.
      flush    = readyIn & clearIn;
      redirect = readyIn & ~clearIn & redirectFlag & ~empty;
      enq      = readyIn & ~clearIn & ~redirect & hit & ~full;
      deq      = readyIn & ~clearIn & ~redirect & deqReady & ~empty;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      fetch_d = fetch_q;

      if (flush || redirect) begin
         head_d  = tail_q;
         count_d = '0;
         fetch_d = flush ? setPCVal : redirectPC;
      end else begin
         if (enq) begin
            tail_d  = tail_q + QUEUE_WIDTH'(1);
            fetch_d = fetch_q + 32'd4;
         end
         if (deq) begin
            head_d = head_q + QUEUE_WIDTH'(1);
         end
         unique case ({enq, deq})
            2'b10:   count_d = count_q + (QUEUE_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (QUEUE_WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clockIn) begin
      if (!resetIn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         fetch_q <= RESET_PC;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fetch_q <= fetch_d;
      end
   end

   // Storage needs no reset; the head is masked to zero whenever the queue is empty.
   always_ff @(posedge clockIn) begin
      if (resetIn && enq) begin
         pc_mem_q[tail_q]   <= fetch_q;
         inst_mem_q[tail_q] <= icacheIn;
      end
   end

   always_comb begin
      fetchOut = fetch_q;
      countOut = count_q;
      fullOut  = full;
      emptyOut = empty;
      deqValid = ~empty;
      deqPC    = empty ? 32'h0 : pc_mem_q[head_q];
      deqInst  = empty ? 32'h0 : inst_mem_q[head_q];
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: depth-8 and depth-2 instances share stimulus; a queue-based
// scoreboard per instance predicts every output each cycle.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n, ready, hit, deq_rdy, redir, clear;
   logic [31:0] icache, redir_pc, set_pc;

   logic [31:0] fetch0, dpc0, dinst0, fetch1, dpc1, dinst1;
   logic        dvalid0, full0, empty0, dvalid1, full1, empty1;
   logic [3:0]  cnt0;
   logic [1:0]  cnt1;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [63:0] sb [2][$];
   logic [31:0] m_fetch [2];
   int          depth   [2] = '{8, 2};
   logic [31:0] rst_pc  [2] = '{32'h0, 32'h1000};

   always #5 clk = ~clk;

   fetch_queue #(.QUEUE_WIDTH(3), .RESET_PC(32'h0)) u_dut0 (
      .clockIn(clk), .resetIn(rst_n), .readyIn(ready), .fetchOut(fetch0), .hit(hit),
      .icacheIn(icache), .deqValid(dvalid0), .deqInst(dinst0), .deqPC(dpc0),
      .deqReady(deq_rdy), .redirectFlag(redir), .redirectPC(redir_pc), .clearIn(clear),
      .setPCVal(set_pc), .countOut(cnt0), .fullOut(full0), .emptyOut(empty0)
   );

   fetch_queue #(.QUEUE_WIDTH(1), .RESET_PC(32'h1000)) u_dut1 (
      .clockIn(clk), .resetIn(rst_n), .readyIn(ready), .fetchOut(fetch1), .hit(hit),
      .icacheIn(icache), .deqValid(dvalid1), .deqInst(dinst1), .deqPC(dpc1),
      .deqReady(deq_rdy), .redirectFlag(redir), .redirectPC(redir_pc), .clearIn(clear),
      .setPCVal(set_pc), .countOut(cnt1), .fullOut(full1), .emptyOut(empty1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input int i, input logic [31:0] f, input logic [31:0] dp,
                             input logic [31:0] di, input logic v, input logic fu,
                             input logic em, input logic [31:0] c);
      int n;
      n = sb[i].size();
      chk($sformatf("count%0d", i), 64'(c), 64'(n));
      chk($sformatf("fetch%0d", i), 64'(f), 64'(m_fetch[i]));
      chk($sformatf("valid%0d", i), 64'(v), 64'(n != 0));
      chk($sformatf("full%0d", i), 64'(fu), 64'(n == depth[i]));
      chk($sformatf("empty%0d", i), 64'(em), 64'(n == 0));
      chk($sformatf("deqpc%0d", i), 64'(dp), (n != 0) ? 64'(sb[i][0][63:32]) : 64'h0);
      chk($sformatf("deqinst%0d", i), 64'(di), (n != 0) ? 64'(sb[i][0][31:0]) : 64'h0);
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            sb[i].delete();
            m_fetch[i] = rst_pc[i];
         end else if (ready) begin
            if (clear) begin
               sb[i].delete();
               m_fetch[i] = set_pc;
            end else if (redir && sb[i].size() > 0) begin
               sb[i].delete();
               m_fetch[i] = redir_pc;
            end else begin
               bit do_deq, do_enq;
               do_deq = deq_rdy && sb[i].size() > 0;
               do_enq = hit && sb[i].size() < depth[i];
               if (do_deq) void'(sb[i].pop_front());
               if (do_enq) begin
                  sb[i].push_back({m_fetch[i], icache});
                  m_fetch[i] = m_fetch[i] + 32'd4;
               end
            end
         end
      end
   endtask

   task automatic step(input bit chk_en);
      if (chk_en) begin
         check_outs(0, fetch0, dpc0, dinst0, dvalid0, full0, empty0, 32'(cnt0));
         check_outs(1, fetch1, dpc1, dinst1, dvalid1, full1, empty1, 32'(cnt1));
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit h, input bit dr, input bit rd, input bit cl);
      hit     = h;
      deq_rdy = dr;
      redir   = rd;
      clear   = cl;
      icache  = $urandom;
   endtask

   initial begin
      rst_n    = 1'b0;
      ready    = 1'b1;
      redir_pc = 32'h100;
      set_pc   = 32'h40;
      drive(1, 1, 1, 1);
      step(0);
      step(0);
      chk("rst_fetch0", 64'(fetch0), 64'h0);
      chk("rst_fetch1", 64'(fetch1), 64'h1000);
      chk("rst_count0", 64'(cnt0), 64'h0);
      chk("rst_empty0", 64'(empty0), 64'h1);
      chk("rst_deqpc0", 64'(dpc0), 64'h0);

      // Fill with no consumer: fetch address stalls once full.
      rst_n = 1'b1;
      repeat (8) begin drive(1, 0, 0, 0); step(1); end
      chk("fill_count0", 64'(cnt0), 64'd8);
      chk("fill_full0", 64'(full0), 64'd1);
      chk("fill_fetch0", 64'(fetch0), 64'd32);
      repeat (3) begin drive(1, 0, 0, 0); step(1); end
      chk("fill_hold0", 64'(fetch0), 64'd32);
      chk("fill_fetch1", 64'(fetch1), 64'h1008);

      // Streaming from reset.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      drive(1, 1, 0, 0);
      step(1);
      for (int k = 0; k < 6; k++) begin
         chk("stream_pc0", 64'(dpc0), 64'(4 * k));
         chk("stream_cnt0", 64'(cnt0), 64'd1);
         drive(1, 1, 0, 0);
         step(1);
      end

      // Redirect with PCs 0..12 queued.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      repeat (4) begin drive(1, 0, 0, 0); step(1); end
      chk("redir_pre_cnt0", 64'(cnt0), 64'd4);
      redir_pc = 32'h100;
      drive(1, 1, 1, 0);
      step(1);
      chk("redir_cnt0", 64'(cnt0), 64'd0);
      chk("redir_fetch0", 64'(fetch0), 64'h100);
      drive(1, 0, 0, 0);
      step(1);
      chk("redir_deqpc0", 64'(dpc0), 64'h100);

      // Flush beats redirect.
      repeat (2) begin drive(1, 0, 0, 0); step(1); end
      set_pc = 32'h40;
      drive(1, 1, 1, 1);
      step(1);
      chk("flush_fetch0", 64'(fetch0), 64'h40);
      chk("flush_cnt0", 64'(cnt0), 64'd0);
      chk("flush_fetch1", 64'(fetch1), 64'h40);

      // Stall: inputs ignored, then reset wins even while stalled.
      repeat (3) begin drive(1, 0, 0, 0); step(1); end
      ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(k[0], ~k[0], k == 2, k == 3);
         step(1);
      end
      rst_n = 1'b0;
      drive(1, 1, 1, 1);
      step(1);
      chk("stall_rst_fetch0", 64'(fetch0), 64'h0);
      chk("stall_rst_fetch1", 64'(fetch1), 64'h1000);
      chk("stall_rst_cnt0", 64'(cnt0), 64'd0);
      rst_n = 1'b1;
      ready = 1'b1;

      // Fetch address wraps at 2^32.
      set_pc = 32'hFFFF_FFF8;
      drive(0, 0, 0, 1);
      step(1);
      repeat (2) begin drive(1, 0, 0, 0); step(1); end
      chk("wrap_fetch0", 64'(fetch0), 64'h0);
      chk("wrap_fetch1", 64'(fetch1), 64'h0);

      // Interleaved enqueue/dequeue drives the depth-2 pointers around several times.
      for (int k = 0; k < 10; k++) begin
         drive(1, (k % 3) != 0, 0, 0);
         step(1);
      end

      // Random mix of everything.
      for (int k = 0; k < 300; k++) begin
         logic [31:0] r;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               (sb[0].size() > 0) && (sb[1].size() > 0) && ($urandom_range(0, 14) == 0),
               $urandom_range(0, 29) == 0);
         ready    = $urandom_range(0, 7) != 0;
         r        = $urandom;
         redir_pc = r & 32'hFFFF_FFFC;
         r        = $urandom;
         set_pc   = r & 32'hFFFF_FFFC;
         rst_n    = $urandom_range(0, 99) != 0;
         step(1);
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 0);
      step(1);
      step(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
